// File: rtl/pio_jmp_exec.sv
// rtl/pio_jmp_exec.sv - JMP condition/execute, X/Y scratch registers and instruction delay counter
// Optional feature macro: PIO_JMP_PIN_SYNC_EN (two-flop synchroniser on jmp_pin_i).
module pio_jmp_exec #(
  parameter int SIDE_BITS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        penable_i,
  input  logic        imm_i,
  input  logic [15:0] instr_i,
  input  logic        stall_in_i,
  input  logic        jmp_pin_i,
  input  logic        osr_empty_i,
  input  logic        x_wr_i,
  input  logic [31:0] x_din_i,
  input  logic        y_wr_i,
  input  logic [31:0] y_din_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic        jmp_o,
  output logic [4:0]  jmp_target_o,
  output logic        delay_busy_o,
  output logic        retire_o
);

  localparam logic [4:0] DELAY_MASK = 5'(5'h1f >> SIDE_BITS);

  typedef enum logic {RUN, DELAY} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic        is_jmp, cond_true, go, busy, pin_val;
  logic [2:0]  cond;
  logic [4:0]  delay;

`ifdef PIO_JMP_PIN_SYNC_EN
  logic pin_meta_q, pin_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_meta_q <= 1'b0;
      pin_sync_q <= 1'b0;
    end else begin
      pin_meta_q <= jmp_pin_i;
      pin_sync_q <= pin_meta_q;
    end
  end

  assign pin_val = pin_sync_q;
`else
  assign pin_val = jmp_pin_i;
`endif

  assign is_jmp = (instr_i[15:13] == 3'b000);
  assign cond   = instr_i[7:5];
  assign delay  = instr_i[12:8] & DELAY_MASK;

  // Outputs are forced low while reset is held, even before the first edge clears state.
  assign busy = (state_q == DELAY) & ~reset;
  assign go   = ~reset & (penable_i | imm_i) & ~stall_in_i & (imm_i | ~busy);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = (x_q == 32'd0);
      3'b010:  cond_true = (x_q != 32'd0);
      3'b011:  cond_true = (y_q == 32'd0);
      3'b100:  cond_true = (y_q != 32'd0);
      3'b101:  cond_true = (x_q != y_q);
      3'b110:  cond_true = pin_val;
      default: cond_true = ~osr_empty_i;
    endcase
  end

  // Explicit loads win over the post-decrement, which is then dropped.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (x_wr_i)
      x_d = x_din_i;
    else if (go && is_jmp && cond == 3'b010)
      x_d = x_q - 32'd1;
    if (y_wr_i)
      y_d = y_din_i;
    else if (go && is_jmp && cond == 3'b100)
      y_d = y_q - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 5'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      case (state_q)
        RUN: begin
          if (go && !imm_i && delay != 5'd0) begin
            state_q <= DELAY;
            cnt_q   <= delay;
          end
        end
        DELAY: begin
          // Immediate instructions run here without touching the countdown.
          if (penable_i) begin
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1)
              state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign jmp_o        = go & is_jmp & cond_true;
  assign jmp_target_o = instr_i[4:0];
  assign delay_busy_o = busy;
  assign retire_o     = go;

endmodule

// File: tb/tb_pio_jmp_exec.sv
// tb/tb_pio_jmp_exec.sv - scoreboard bench for pio_jmp_exec
module tb_pio_jmp_exec;

  logic        clk, reset, penable_i, imm_i, stall_in_i, jmp_pin_i, osr_empty_i;
  logic [15:0] instr_i;
  logic        x_wr_i, y_wr_i;
  logic [31:0] x_din_i, y_din_i, x_o, y_o;
  logic        jmp_o, delay_busy_o, retire_o;
  logic [4:0]  jmp_target_o;

  pio_jmp_exec #(.SIDE_BITS(0)) dut (
    .clk(clk), .reset(reset), .penable_i(penable_i), .imm_i(imm_i), .instr_i(instr_i),
    .stall_in_i(stall_in_i), .jmp_pin_i(jmp_pin_i), .osr_empty_i(osr_empty_i),
    .x_wr_i(x_wr_i), .x_din_i(x_din_i), .y_wr_i(y_wr_i), .y_din_i(y_din_i),
    .x_o(x_o), .y_o(y_o), .jmp_o(jmp_o), .jmp_target_o(jmp_target_o),
    .delay_busy_o(delay_busy_o), .retire_o(retire_o)
  );

  typedef struct packed {
    logic        jmp;
    logic [4:0]  tgt;
    logic        ret;
    logic        busy;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  typedef struct packed {
    logic        rst, pen, imm, stall;
    logic [15:0] ins;
    logic        xwr;
    logic [31:0] xd;
    logic        ywr;
    logic [31:0] yd;
    logic        pin, osre;
    exp_t        e;
  } stim_t;

  stim_t stim_q[$];
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, pen, imm, stall, input logic [15:0] ins,
                     input logic xwr, input logic [31:0] xd, input logic ywr, input logic [31:0] yd,
                     input logic pin, osre, ej, er, eb, input logic [31:0] ex, ey);
    stim_t s;
    s.rst = rst; s.pen = pen; s.imm = imm; s.stall = stall; s.ins = ins;
    s.xwr = xwr; s.xd = xd; s.ywr = ywr; s.yd = yd; s.pin = pin; s.osre = osre;
    s.e = '{jmp: ej, tgt: ins[4:0], ret: er, busy: eb, x: ex, y: ey};
    stim_q.push_back(s);
  endtask

  task automatic drive(input stim_t s);
    reset = s.rst; penable_i = s.pen; imm_i = s.imm; stall_in_i = s.stall; instr_i = s.ins;
    x_wr_i = s.xwr; x_din_i = s.xd; y_wr_i = s.ywr; y_din_i = s.yd;
    jmp_pin_i = s.pin; osr_empty_i = s.osre;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e, got; int k = 0;
    add(1, 1, 0, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(1, 1, 1, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_jmp_xdec();
    stim_t s; exp_t e, got; int k = 0;
    add(0, 0, 0, 0, 16'h0000, 1, 32'd3, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd3, 32'd0);
    add(0, 1, 0, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd2, 32'd0);
    add(0, 1, 0, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd1, 32'd0);
    add(0, 1, 0, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd0);
    add(0, 0, 0, 0, 16'h0045, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL jmp_xdec step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_conditions();
    stim_t s; exp_t e, got; int k = 0;
    add(0, 0, 0, 0, 16'h0000, 1, 32'd0, 1, 32'd7, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd0);
    add(0, 1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h0022, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h0063, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h00A4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h00C5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h00C5, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h00E6, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h00E6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h2007, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd7);
    add(0, 1, 0, 0, 16'h0088, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd7);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd6);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL conditions step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_delay();
    stim_t s; exp_t e, got; int k = 0;
    add(0, 0, 0, 0, 16'h0000, 0, 0, 1, 32'd0, 0, 0, 0, 0, 0, 32'd0, 32'd6);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    add(0, 0, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++)
      add(0, (i % 2 == 1), 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    add(0, 0, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL delay step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_imm_in_delay();
    stim_t s; exp_t e, got; int k = 0;
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    add(0, 0, 1, 0, 16'h0007, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    add(0, 0, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    add(0, 0, 1, 0, 16'h1F07, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL imm_in_delay step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_priority();
    stim_t s; exp_t e, got; int k = 0;
    add(0, 0, 0, 0, 16'h0000, 1, 32'd5, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    add(0, 1, 0, 1, 16'h0042, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'd0);
    add(0, 1, 0, 1, 16'h0042, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'd0);
    add(0, 1, 0, 0, 16'h0042, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd5, 32'd0);
    add(0, 0, 0, 0, 16'h0042, 1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 32'd4, 32'd0);
    add(0, 1, 0, 0, 16'h0042, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0088, 0, 0, 1, 32'h20, 0, 0, 0, 1, 0, 32'h10, 32'd0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h20);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL stall_priority step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_delay();
    stim_t s; exp_t e, got; int k = 0;
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 32'h20);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h20);
    add(1, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h20);
    add(0, 0, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd0, 32'd0);
    add(0, 1, 0, 0, 16'h0363, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); drive(s); sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front();
      got = {jmp_o, jmp_target_o, retire_o, delay_busy_o, x_o, y_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid_delay step %0d: got jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h, expected jmp=%b tgt=%0d ret=%b busy=%b x=%h y=%h",
                 k, got.jmp, got.tgt, got.ret, got.busy, got.x, got.y, e.jmp, e.tgt, e.ret, e.busy, e.x, e.y);
      end
      k++; @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; penable_i = 1'b0; imm_i = 1'b0; stall_in_i = 1'b0; instr_i = 16'h0;
    x_wr_i = 1'b0; x_din_i = 32'h0; y_wr_i = 1'b0; y_din_i = 32'h0;
    jmp_pin_i = 1'b0; osr_empty_i = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_jmp_xdec();
    test_conditions();
    test_delay();
    test_imm_in_delay();
    test_stall_priority();
    test_reset_mid_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
